// File: rtl/buf_pkg.sv
// Shared constants and helpers for the buffered FIFO and its RAM.
package buf_pkg;

    // Address width of the default configuration.
    localparam int unsigned BUF_DEF_ADDR_WIDTH = 4;

    // Occupancy type for the default configuration: one bit wider than the
    // address so that a completely full buffer can be represented.
    typedef logic [BUF_DEF_ADDR_WIDTH:0] buf_count_t;

    // Number of entries addressed by a given address width.
    function automatic int unsigned buf_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // An almost-full threshold is meaningful only between one entry and the
    // full depth of the buffer.
    function automatic bit af_thresh_legal(input int unsigned thresh,
                                           input int unsigned addr_width);
        return (thresh >= 32'd1) && (thresh <= buf_depth(addr_width));
    endfunction

endpackage

// File: rtl/buf_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module buf_ram
    import buf_pkg::*;
#(
    parameter int G_BUF_ADDR_WIDTH = 4,
    parameter int G_BUF_DATA_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        wr_en,
    input  logic [G_BUF_ADDR_WIDTH-1:0] wr_addr,
    input  logic [G_BUF_DATA_WIDTH-1:0] wr_data,
    input  logic                        rd_en,
    input  logic [G_BUF_ADDR_WIDTH-1:0] rd_addr,
    output logic [G_BUF_DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = buf_depth(G_BUF_ADDR_WIDTH);

    logic [G_BUF_DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array; deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; cleared by reset or clr, otherwise holds its value between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (clr) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/buf_fifo.sv
// Synchronous FIFO with valid/ready handshakes on both sides. Words are
// held in buf_ram, and the RAM read register forms a one-word output stage.
module buf_fifo
    import buf_pkg::*;
#(
    parameter int G_BUF_ADDR_WIDTH = 4,
    parameter int G_BUF_DATA_WIDTH = 8,
    parameter int G_AF_THRESH      = 12
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        wr_valid_i,
    output logic                        wr_ready_o,
    input  logic [G_BUF_DATA_WIDTH-1:0] wr_data_i,
    output logic                        rd_valid_o,
    input  logic                        rd_ready_i,
    output logic [G_BUF_DATA_WIDTH-1:0] rd_data_o,
    output logic [G_BUF_ADDR_WIDTH:0]   count_o,
    output logic                        almost_full_o,
    output logic                        overflow_o
);

    localparam int unsigned DEPTH = buf_depth(G_BUF_ADDR_WIDTH);

    typedef logic [G_BUF_ADDR_WIDTH:0]   count_t;
    typedef logic [G_BUF_ADDR_WIDTH-1:0] ptr_t;

    localparam count_t DEPTH_C = count_t'(DEPTH);
    localparam count_t AF_C    = count_t'(G_AF_THRESH);
    localparam ptr_t   PTR_ONE = ptr_t'(1);

    if (!af_thresh_legal(G_AF_THRESH, G_BUF_ADDR_WIDTH)) begin : g_bad_thresh
        $error("buf_fifo: G_AF_THRESH must lie between 1 and the buffer depth");
    end

    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    count_t mem_cnt;
    logic   out_valid;
    logic   almost_full;
    logic   overflow;

    count_t total;
    count_t total_nxt;
    count_t mem_cnt_nxt;
    logic   out_valid_nxt;
    logic   wr_ready;
    logic   wr_fire;
    logic   rd_fire;
    logic   pop;

    // Handshake decisions and next-state occupancy. wr_ready depends only on
    // registered state, so a pop never frees a slot for a write in the same cycle.
    always_comb begin
        total         = mem_cnt + count_t'(out_valid);
        wr_ready      = (total < DEPTH_C);
        wr_fire       = wr_valid_i & wr_ready & ~flush_i;
        pop           = out_valid & rd_ready_i;
        rd_fire       = (mem_cnt != '0) & (~out_valid | rd_ready_i) & ~flush_i;
        mem_cnt_nxt   = mem_cnt + count_t'(wr_fire) - count_t'(rd_fire);
        out_valid_nxt = rd_fire | (out_valid & ~pop);
        total_nxt     = mem_cnt_nxt + count_t'(out_valid_nxt);
    end

    // Pointers, counters, output-stage flag and status flags. Flush returns all of them to the reset state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            mem_cnt     <= '0;
            out_valid   <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            mem_cnt     <= mem_cnt_nxt;
            out_valid   <= out_valid_nxt;
            almost_full <= (total_nxt >= AF_C);
            if (wr_valid_i & ~wr_ready) begin
                overflow <= 1'b1;
            end
        end
    end

    buf_ram #(
        .G_BUF_ADDR_WIDTH(G_BUF_ADDR_WIDTH),
        .G_BUF_DATA_WIDTH(G_BUF_DATA_WIDTH)
    ) u_ram (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (flush_i),
        .wr_en  (wr_fire),
        .wr_addr(wr_ptr),
        .wr_data(wr_data_i),
        .rd_en  (rd_fire),
        .rd_addr(rd_ptr),
        .rd_data(rd_data_o)
    );

    assign wr_ready_o    = wr_ready;
    assign rd_valid_o    = out_valid;
    assign count_o       = total;
    assign almost_full_o = almost_full;
    assign overflow_o    = overflow;

endmodule

// File: tb/tb_buf_fifo.sv
// Self-checking bench for buf_fifo: status vectors plus a data scoreboard.
module tb_buf_fifo;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    typedef struct {
        bit          wv;
        logic [7:0]  wd;
        bit          rr;
        bit          fl;
        int          ecount;
        bit          evalid;
        bit          ewready;
        bit          eaf;
        bit          eovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wv;
    logic          rr;
    logic [DW-1:0] wd;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;
    logic          af;
    logic          ovf;

    vec_t          vecs[$];
    logic [7:0]    sb[$];
    int            checks   = 0;
    int            errors   = 0;
    int            received = 0;

    always #5 clk = ~clk;

    buf_fifo #(
        .G_BUF_ADDR_WIDTH(AW),
        .G_BUF_DATA_WIDTH(DW),
        .G_AF_THRESH     (AF)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .wr_valid_i   (wv),
        .wr_ready_o   (wr_ready),
        .wr_data_i    (wd),
        .rd_valid_o   (rd_valid),
        .rd_ready_i   (rr),
        .rd_data_o    (rd_data),
        .count_o      (count),
        .almost_full_o(af),
        .overflow_o   (ovf)
    );

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int ec, input bit ev,
                               input bit ewr, input bit eaf, input bit eov);
        checkValue({tag, " count"},       int'(count),    ec);
        checkValue({tag, " rd_valid"},    int'(rd_valid), int'(ev));
        checkValue({tag, " wr_ready"},    int'(wr_ready), int'(ewr));
        checkValue({tag, " almost_full"}, int'(af),       int'(eaf));
        checkValue({tag, " overflow"},    int'(ovf),      int'(eov));
    endtask

    // Drives one cycle. At the falling edge the head word is compared with
    // the scoreboard (also while stalled) and popped when consumed; accepted
    // writes are pushed. Returns just after the next rising edge.
    task automatic applyStimulus(input bit w, input logic [7:0] d, input bit r,
                                 input bit f, input bit use_model,
                                 input bit model_acc, output bit acc);
        wv    = w;
        wd    = d;
        rr    = r;
        flush = f;
        @(negedge clk);
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL head: rd_valid=1 with data %0d, expected no word", rd_data);
            end else begin
                checkValue("head data", int'(rd_data), int'(sb[0]));
                if (r && !f) begin
                    void'(sb.pop_front());
                    received++;
                end
            end
        end
        acc = use_model ? model_acc : (w && !f && wr_ready);
        if (acc) sb.push_back(d);
        @(posedge clk);
        #1;
        if (f) sb.delete();
        wv    = 1'b0;
        rr    = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit         acc;
        bit         macc;
        bit         w;
        bit         r;
        int         prev;
        int         sent;
        int         cyc;
        logic [7:0] d;

        rst   = 1'b1;
        flush = 1'b0;
        wv    = 1'b0;
        rr    = 1'b0;
        wd    = '0;
        #12;
        checkOutput("reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkValue("reset rd_data", int'(rd_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Status vectors: single word, fill past full, drain, flush.
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0});
        for (int k = 1; k <= DEPTH; k++)
            vecs.push_back('{1'b1, 8'(k - 1), 1'b0, 1'b0, k, k >= 2, k < DEPTH, k >= AF, 1'b0});
        vecs.push_back('{1'b1, 8'hEE, 1'b0, 1'b0, DEPTH, 1'b1, 1'b0, 1'b1, 1'b1});
        for (int j = 1; j <= DEPTH; j++)
            vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, DEPTH - j, j < DEPTH, 1'b1, (DEPTH - j) >= AF, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0});

        prev = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            macc = vecs[i].wv && !vecs[i].fl && (prev < DEPTH);
            applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].rr, vecs[i].fl, 1'b1, macc, acc);
            checkOutput($sformatf("vec%0d", i), vecs[i].ecount, vecs[i].evalid,
                        vecs[i].ewready, vecs[i].eaf, vecs[i].eovf);
            prev = vecs[i].ecount;
        end

        // Streaming 40 words with random stalls on both sides.
        sent     = 0;
        received = 0;
        cyc      = 0;
        sb.delete();
        while ((sent < 40 || received < 40) && cyc < 2000) begin
            w = (sent < 40) && ($urandom_range(0, 3) != 0) && wr_ready;
            r = ($urandom_range(0, 3) != 0);
            d = 8'($urandom_range(0, 255));
            applyStimulus(w, d, r, 1'b0, 1'b0, 1'b0, acc);
            if (acc) sent++;
            cyc++;
        end
        checkValue("stream words received", received, 40);
        checkOutput("stream end", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Flush while holding five words, with a simultaneous write.
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, 1'b1, 1'b1, acc);
        checkOutput("pre-flush", 5, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        checkOutput("flush", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("post-flush idle", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("post-flush word", 1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkValue("post-flush data", int'(rd_data), 8'h3C);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("post-flush drained", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle with seven words held.
        for (int k = 0; k < 7; k++)
            applyStimulus(1'b1, 8'(8'h60 + k), 1'b0, 1'b0, 1'b1, 1'b1, acc);
        checkOutput("pre-reset", 7, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkValue("async reset rd_data", int'(rd_data), 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("after release", 0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("A5 held", 1, 1'b1, 1'b1, 1'b0, 1'b0);
        checkValue("A5 data", int'(rd_data), 8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        checkOutput("A5 popped", 0, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/buf_fifo.md
Name: buf_fifo

Overview:
Parametrised synchronous FIFO built on a registered-read dual-port buffer RAM.
- Adds valid/ready handshakes on both sides, occupancy tracking, almost-full flag, synchronous flush and sticky overflow detect.
- Sits between producer and consumer stages in the same clock domain, where a bare RAM buffer needs external pointer logic.

Parameters:
- G_BUF_ADDR_WIDTH, 4: RAM address width; DEPTH = 2**G_BUF_ADDR_WIDTH entries, which is also total FIFO capacity.
- G_BUF_DATA_WIDTH, 8: data word width.
- G_AF_THRESH, 12: almost_full_o asserts when count_o >= G_AF_THRESH; legal range 1..DEPTH.

Ports:
- clk_i, in, 1: clock, rising edge.
- rst_i, in, 1: asynchronous active-high reset.
- flush_i, in, 1: synchronous clear of all contents.
- wr_valid_i, in, 1: producer has a word.
- wr_ready_o, out, 1: FIFO can accept a word.
- wr_data_i, in, G_BUF_DATA_WIDTH: write data.
- rd_valid_o, out, 1: rd_data_o holds the head word.
- rd_ready_i, in, 1: consumer takes the head word.
- rd_data_o, out, G_BUF_DATA_WIDTH: head word.
- count_o, out, G_BUF_ADDR_WIDTH+1: total words held (RAM plus output stage).
- almost_full_o, out, 1: count_o >= G_AF_THRESH.
- overflow_o, out, 1: sticky; set when a write is attempted while full.

Behaviour:
- Reset (async, rst_i=1): pointers=0, counts=0, rd_valid_o=0, rd_data_o=0, wr_ready_o=1, almost_full_o=0, overflow_o=0. RAM contents are not reset.
- Write: accepted on an edge where wr_valid_i & wr_ready_o. Data is stored at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap).
- wr_ready_o = (count_o < DEPTH). It is a function of registered state only, with no combinational path from rd_ready_i. A pop and a write in the same cycle at full is therefore not possible; the write waits one cycle.
- Output stage: rd_data_o is the RAM's registered read port; out_valid is a flag register driving rd_valid_o.
- Prefetch: a RAM read is issued at rd_ptr on an edge when mem_cnt > 0 and (out_valid=0 or rd_ready_i=1). On that edge rd_ptr increments, mem_cnt decrements and out_valid is set.
- Pop with no prefetch (rd_valid_o & rd_ready_i, mem_cnt=0): out_valid clears and rd_data_o holds its stale value.
- Latency: a word written into an empty FIFO at edge N appears with rd_valid_o=1 after edge N+1. Back-to-back pops sustain one word per cycle while mem_cnt > 0.
- rd_data_o and rd_valid_o are stable while rd_valid_o=1 and rd_ready_i=0.
- Counting: count_o = mem_cnt + out_valid, updated on every edge.
  - Simultaneous accepted write and pop leaves count_o unchanged.
  - Write while mem_cnt increments and the prefetch decrements updates both fields consistently.
- No read/write address collision: a write requires total < DEPTH and a read requires mem_cnt > 0, so the two pointers never match on the same edge. No bypass logic is required.
- almost_full_o is registered and reflects count_o after the same edge.
- Overflow: wr_valid_i & !wr_ready_o at an edge sets overflow_o. The data is dropped and the state is unchanged. overflow_o clears only on flush_i or reset.
- Flush (flush_i=1 at an edge): same end state as reset, except the RAM is untouched. Flush has priority over a simultaneous write or pop, which are ignored. wr_ready_o=1 after the edge.
- Reset asserted mid-transfer: all state returns immediately to reset values. The in-flight word is lost, and after release the FIFO reads empty.

Decomposition:
- Shared package buf_pkg: function clog2-free depth constant helper, typedef for the count width, and the G_AF_THRESH legality check (elaboration assertion).
- One sub-module, buf_ram: simple dual-port RAM with registered read and write enable, parametrised by G_BUF_ADDR_WIDTH and G_BUF_DATA_WIDTH.
- buf_fifo holds the pointers, counters, out_valid, flags and handshake logic.

Test Plan:
- Reset, then write 0x11 with rd_ready_i=0 -> rd_valid_o=1, rd_data_o=0x11 one cycle after acceptance; count_o=1.
- Write 16 words 0x00..0x0F, no reads -> wr_ready_o=0 after the 16th; count_o=16; almost_full_o=1 from count 12. A 17th write sets overflow_o=1 and count_o stays 16.
- Full FIFO, rd_ready_i=1 for 16 cycles -> rd_data_o sequence 0x00..0x0F at one word per cycle; then rd_valid_o=0, count_o=0, wr_ready_o=1 from the first pop's next cycle.
- Continuous write and read for 40 words (pointer wraps twice) with random rd_ready_i stalls -> output order matches input, and data holds stable during stalls.
- FIFO holding 5 words, flush_i=1 together with wr_valid_i=1 -> next cycle count_o=0, rd_valid_o=0, overflow_o=0, and the write is not stored.
- Assert rst_i asynchronously mid-cycle while count_o=7 -> outputs reach reset values before the next edge; after release, a write of 0xA5 reads back as 0xA5.
